// File: rtl/vga_state_pkg.sv
// ---------------------------------------------------------------------------
// vga_state_pkg
// Shared definitions for the 128-bit player-state word (pNVGA) exchanged
// between the per-player state packer and the vga_controller decode.
// Contents: word width, bit position of every field, action bit indices,
// stick direction encodings, packer FSM state type, the field bundle struct
// and a helper that overwrites the walk-phase bit of a word.
// ---------------------------------------------------------------------------
package vga_state_pkg;

    localparam int PVGA_W       = 128;

    // Field positions inside the published word
    localparam int X_LSB        = 0;
    localparam int X_W          = 11;
    localparam int Y_LSB        = 11;
    localparam int Y_W          = 10;
    localparam int SPEED_LSB    = 69;
    localparam int SPEED_W      = 3;
    localparam int DIR_LSB      = 78;
    localparam int DIR_W        = 2;
    localparam int ACT_LSB      = 101;
    localparam int ACT_W        = 6;
    localparam int GROUNDED_BIT = 113;
    localparam int PHASE_BIT    = 114;

    // Index of each action inside the action field
    localparam int ACT_A        = 0;
    localparam int ACT_UPB      = 1;
    localparam int ACT_DOWNB    = 2;
    localparam int ACT_SIDEB_L  = 3;
    localparam int ACT_SIDEB_R  = 4;
    localparam int ACT_NEUTRALB = 5;

    // Stick direction encodings (00 and 11 both mean no direction)
    localparam logic [1:0] DIR_NONE     = 2'b00;
    localparam logic [1:0] DIR_LEFT     = 2'b01;
    localparam logic [1:0] DIR_RIGHT    = 2'b10;
    localparam logic [1:0] DIR_NONE_ALT = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } pack_state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [ACT_W-1:0]   action;
        logic [DIR_W-1:0]   dir;
        logic [SPEED_W-1:0] speed;
        logic               grounded;
    } player_fields_t;

    // Returns the word with its walk-phase bit replaced by ph
    function automatic logic [PVGA_W-1:0] set_phase(input logic [PVGA_W-1:0] w,
                                                    input logic              ph);
        logic [PVGA_W-1:0] r;
        r            = w;
        r[PHASE_BIT] = ph;
        return r;
    endfunction

endpackage

// File: rtl/vga_state_pack.sv
// ---------------------------------------------------------------------------
// vga_state_pack
// Purely combinational packer: player field bundle -> 128-bit state word.
// The walk-phase bit is left at 0; the owner of the word inserts it.
// Optional macro VGA_POS_CLAMP_EN: clamp x to [X_MIN,X_MAX] and y to
// [0,Y_MAX] before packing. Without it x/y are packed verbatim.
// Ports:
//   fields  in  player_fields_t  raw fields from game logic
//   word    out 128              packed word, phase bit 0, unused bits 0
// ---------------------------------------------------------------------------
module vga_state_pack
    import vga_state_pkg::*;
#(
    parameter int X_MIN = 256,
    parameter int X_MAX = 895,
    parameter int Y_MAX = 479
) (
    input  player_fields_t    fields,
    output logic [PVGA_W-1:0] word
);

    logic [X_W-1:0] x_s;
    logic [Y_W-1:0] y_s;

    // Position conditioning (clamp or pass-through)
    always_comb begin
        x_s = fields.x;
        y_s = fields.y;
`ifdef VGA_POS_CLAMP_EN
        if (fields.x < X_W'(X_MIN)) begin
            x_s = X_W'(X_MIN);
        end else if (fields.x > X_W'(X_MAX)) begin
            x_s = X_W'(X_MAX);
        end else begin
            x_s = fields.x;
        end
        if (fields.y > Y_W'(Y_MAX)) begin
            y_s = Y_W'(Y_MAX);
        end else begin
            y_s = fields.y;
        end
`else
        x_s = fields.x;
        y_s = fields.y;
`endif
    end

    // Field placement; multiple action bits pass through untouched
    always_comb begin
        word                           = {PVGA_W{1'b0}};
        word[X_LSB +: X_W]             = x_s;
        word[Y_LSB +: Y_W]             = y_s;
        word[SPEED_LSB +: SPEED_W]     = fields.speed;
        word[DIR_LSB +: DIR_W]         = fields.dir;
        word[ACT_LSB +: ACT_W]         = fields.action;
        word[GROUNDED_BIT]             = fields.grounded;
    end

endmodule

// File: rtl/vga_player_state_packer.sv
// ---------------------------------------------------------------------------
// vga_player_state_packer
// Producer end of the player-state bus read by the VGA renderer. Game logic
// writes field updates over valid/ready into a shadow word; the shadow is
// published to oPVGA only at the falling edge of vertical sync so a frame
// never shows a half-updated sprite. Also runs the walk-animation phase.
// Optional macro VGA_POS_CLAMP_EN (in vga_state_pack): clamp position.
// Ports:
//   iVGA_CLK    in   pixel clock, posedge
//   iRST_n      in   asynchronous active-low reset
//   iVS         in   vertical sync, active-low, same clock domain
//   iUpd_valid  in   update presented
//   oUpd_ready  out  update accepted when iUpd_valid & oUpd_ready
//   iPos_x/iPos_y/iAction/iDir/iSpeed/iGrounded  in  update fields
//   oPVGA       out  published 128-bit state word
//   oCommit     out  1-cycle pulse, oPVGA carries a new shadow this cycle
//   oFrame_cnt  out  frames since reset, wraps
//   oDrop_cnt   out  updates overwritten before publication, saturating
// ---------------------------------------------------------------------------
module vga_player_state_packer
    import vga_state_pkg::*;
#(
    parameter int ANIM_DIV = 8,
    parameter int X_MIN    = 256,
    parameter int X_MAX    = 895,
    parameter int Y_MAX    = 479
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic               iVS,
    input  logic               iUpd_valid,
    output logic               oUpd_ready,
    input  logic [10:0]        iPos_x,
    input  logic [9:0]         iPos_y,
    input  logic [5:0]         iAction,
    input  logic [1:0]         iDir,
    input  logic [2:0]         iSpeed,
    input  logic               iGrounded,
    output logic [PVGA_W-1:0]  oPVGA,
    output logic               oCommit,
    output logic [15:0]        oFrame_cnt,
    output logic [7:0]         oDrop_cnt
);

    localparam int PH_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    pack_state_t       state_r;
    pack_state_t       state_nxt_s;
    logic              vs_d_r;
    logic              frame_start_s;
    logic              commit_cycle_s;
    logic              ready_r;
    logic              accept_s;
    player_fields_t    fields_s;
    logic [PVGA_W-1:0] packed_s;
    logic [PVGA_W-1:0] shadow_r;
    logic              dirty_r;
    logic [PH_W-1:0]   phase_cnt_r;
    logic              phase_r;
    logic              phase_wrap_s;
    logic              phase_nxt_s;
    logic [PVGA_W-1:0] pvga_r;
    logic              commit_r;
    logic [15:0]       frame_cnt_r;
    logic [7:0]        drop_cnt_r;

    assign fields_s = '{x: iPos_x, y: iPos_y, action: iAction, dir: iDir,
                        speed: iSpeed, grounded: iGrounded};

    vga_state_pack #(
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_pack (
        .fields (fields_s),
        .word   (packed_s)
    );

    // Sync delay for VS edge detect; resets high so release is not an edge
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_d_r <= 1'b1;
        end else begin
            vs_d_r <= iVS;
        end
    end

    assign frame_start_s = vs_d_r & ~iVS;

    // FSM state register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: one COMMIT cycle per VS falling edge
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (frame_start_s) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        commit_cycle_s = 1'b0;
        case (state_r)
            ST_IDLE:   commit_cycle_s = 1'b0;
            ST_COMMIT: commit_cycle_s = 1'b1;
            default:   commit_cycle_s = 1'b0;
        endcase
    end

    // Ready is registered from the next state so it is low exactly in COMMIT
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ready_r <= 1'b1;
        end else begin
            ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    assign accept_s = iUpd_valid & ready_r;

    // Shadow word and dirty flag; accepts never coincide with COMMIT
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            shadow_r <= {PVGA_W{1'b0}};
            dirty_r  <= 1'b0;
        end else if (accept_s) begin
            shadow_r <= packed_s;
            dirty_r  <= 1'b1;
        end else if (commit_cycle_s) begin
            dirty_r  <= 1'b0;
        end else begin
            dirty_r  <= dirty_r;
        end
    end

    // Overwrite counter: an accept onto an unpublished shadow is a drop
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            drop_cnt_r <= 8'd0;
        end else if (accept_s && dirty_r && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign phase_wrap_s = (phase_cnt_r == PH_W'(ANIM_DIV - 1));
    assign phase_nxt_s  = phase_r ^ phase_wrap_s;

    // Frame and animation-phase counters advance once per COMMIT
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            frame_cnt_r <= 16'd0;
            phase_cnt_r <= {PH_W{1'b0}};
            phase_r     <= 1'b0;
        end else if (commit_cycle_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            phase_r     <= phase_nxt_s;
            if (phase_wrap_s) begin
                phase_cnt_r <= {PH_W{1'b0}};
            end else begin
                phase_cnt_r <= phase_cnt_r + {{(PH_W-1){1'b0}}, 1'b1};
            end
        end else begin
            frame_cnt_r <= frame_cnt_r;
            phase_cnt_r <= phase_cnt_r;
            phase_r     <= phase_r;
        end
    end

    // Publication: full shadow when dirty, otherwise only the phase bit moves
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pvga_r   <= {PVGA_W{1'b0}};
            commit_r <= 1'b0;
        end else if (commit_cycle_s) begin
            if (dirty_r) begin
                pvga_r   <= set_phase(shadow_r, phase_nxt_s);
                commit_r <= 1'b1;
            end else begin
                pvga_r   <= set_phase(pvga_r, phase_nxt_s);
                commit_r <= 1'b0;
            end
        end else begin
            pvga_r   <= pvga_r;
            commit_r <= 1'b0;
        end
    end

    assign oUpd_ready = ready_r;
    assign oPVGA      = pvga_r;
    assign oCommit    = commit_r;
    assign oFrame_cnt = frame_cnt_r;
    assign oDrop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_vga_player_state_packer.sv
module tb_vga_player_state_packer;

    localparam int ANIM_DIV = 8;

    logic         clk = 1'b0;
    logic         iRST_n;
    logic         iVS;
    logic         iUpd_valid;
    logic         oUpd_ready;
    logic [10:0]  iPos_x;
    logic [9:0]   iPos_y;
    logic [5:0]   iAction;
    logic [1:0]   iDir;
    logic [2:0]   iSpeed;
    logic         iGrounded;
    logic [127:0] oPVGA;
    logic         oCommit;
    logic [15:0]  oFrame_cnt;
    logic [7:0]   oDrop_cnt;

    always #5 clk = ~clk;

    vga_player_state_packer #(.ANIM_DIV(ANIM_DIV), .X_MIN(256), .X_MAX(895), .Y_MAX(479)) dut (
        .iVGA_CLK   (clk),
        .iRST_n     (iRST_n),
        .iVS        (iVS),
        .iUpd_valid (iUpd_valid),
        .oUpd_ready (oUpd_ready),
        .iPos_x     (iPos_x),
        .iPos_y     (iPos_y),
        .iAction    (iAction),
        .iDir       (iDir),
        .iSpeed     (iSpeed),
        .iGrounded  (iGrounded),
        .oPVGA      (oPVGA),
        .oCommit    (oCommit),
        .oFrame_cnt (oFrame_cnt),
        .oDrop_cnt  (oDrop_cnt)
    );

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [5:0]  act;
        logic [1:0]  dir;
        logic [2:0]  spd;
        logic        gnd;
        logic [10:0] ex;
        logic [9:0]  ey;
    } vec_t;

    vec_t vecs[5];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model of the published state
    logic [127:0] exp_q[$];
    logic [127:0] m_cur   = 128'd0;
    logic [127:0] m_pend  = 128'd0;
    logic         m_dirty = 1'b0;
    logic         m_phase = 1'b0;
    int           m_pcnt  = 0;
    int           m_frames = 0;
    int           m_drop  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [127:0] exp_word(input logic [10:0] x, input logic [9:0] y,
                                              input logic [5:0] act, input logic [1:0] dir,
                                              input logic [2:0] spd, input logic gnd,
                                              input logic ph);
        logic [127:0] w;
        w = 128'd0;
        w[10:0]    = x;
        w[20:11]   = y;
        w[71:69]   = spd;
        w[79:78]   = dir;
        w[106:101] = act;
        w[113]     = gnd;
        w[114]     = ph;
        return w;
    endfunction

    // Scoreboard consumer: every commit pulse must match the oldest expectation
    always @(negedge clk) begin
        if (iRST_n && oCommit) begin
            if (exp_q.size() == 0) check("unexpected_commit", {127'd0, oCommit}, 128'd0);
            else check("commit_word", oPVGA, exp_q.pop_front());
        end
    end

    task automatic model_reset();
        m_cur = 128'd0; m_pend = 128'd0; m_dirty = 1'b0; m_phase = 1'b0;
        m_pcnt = 0; m_frames = 0; m_drop = 0;
        exp_q.delete();
    endtask

    // Called at a negedge; presents an update and holds it until accepted
    task automatic do_accept(input logic [10:0] x, input logic [9:0] y, input logic [5:0] act,
                             input logic [1:0] dir, input logic [2:0] spd, input logic gnd,
                             input logic [10:0] ex, input logic [9:0] ey);
        int waited;
        waited = 0;
        iPos_x = x; iPos_y = y; iAction = act; iDir = dir; iSpeed = spd; iGrounded = gnd;
        iUpd_valid = 1'b1;
        while (!oUpd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!oUpd_ready) check("accept_timeout", {127'd0, oUpd_ready}, 128'd1);
        @(negedge clk);
        iUpd_valid = 1'b0;
        if (m_dirty && m_drop != 255) m_drop++;
        m_pend  = exp_word(ex, ey, act, dir, spd, gnd, 1'b0);
        m_dirty = 1'b1;
    endtask

    // Called at a negedge; one VS low pulse, optionally with an update offered in COMMIT
    task automatic do_frame(input bit stall_upd);
        iVS = 1'b0;
        m_frames++;
        if (m_pcnt == ANIM_DIV - 1) begin m_pcnt = 0; m_phase = ~m_phase; end
        else m_pcnt++;
        if (m_dirty) begin
            m_cur = m_pend;
            m_cur[114] = m_phase;
            exp_q.push_back(m_cur);
            m_dirty = 1'b0;
        end else begin
            m_cur[114] = m_phase;
        end
        @(negedge clk);
        check("ready_low_in_commit", {127'd0, oUpd_ready}, 128'd0);
        if (stall_upd) begin
            iPos_x = 11'd500; iPos_y = 10'd200; iAction = 6'b000010;
            iDir = 2'b10; iSpeed = 3'd5; iGrounded = 1'b1;
            iUpd_valid = 1'b1;
        end
        @(negedge clk);
        if (stall_upd) begin
            check("ready_after_commit", {127'd0, oUpd_ready}, 128'd1);
            check("stalled_not_in_this_frame", {127'd0, oCommit}, 128'd0);
            @(negedge clk);
            iUpd_valid = 1'b0;
            m_pend  = exp_word(11'd500, 10'd200, 6'b000010, 2'b10, 3'd5, 1'b1, 1'b0);
            m_dirty = 1'b1;
        end
        repeat (4) @(negedge clk);
        iVS = 1'b1;
        repeat (4) @(negedge clk);
        check("pvga_after_frame", oPVGA, m_cur);
        check("frame_cnt", {112'd0, oFrame_cnt}, 128'(m_frames));
        check("commit_missing", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        vecs[0] = '{11'd300,  10'd100, 6'b000001, 2'b00, 3'd0, 1'b1, 11'd300, 10'd100};
        vecs[1] = '{11'd895,  10'd479, 6'b100000, 2'b10, 3'd7, 1'b0, 11'd895, 10'd479};
        vecs[2] = '{11'd256,  10'd0,   6'b011000, 2'b01, 3'd3, 1'b1, 11'd256, 10'd0};
`ifdef VGA_POS_CLAMP_EN
        vecs[3] = '{11'd100,  10'd600,  6'b000100, 2'b11, 3'd2, 1'b0, 11'd256, 10'd479};
        vecs[4] = '{11'd2047, 10'd1023, 6'b010000, 2'b10, 3'd6, 1'b1, 11'd895, 10'd479};
`else
        vecs[3] = '{11'd100,  10'd600,  6'b000100, 2'b11, 3'd2, 1'b0, 11'd100, 10'd600};
        vecs[4] = '{11'd2047, 10'd1023, 6'b010000, 2'b10, 3'd6, 1'b1, 11'd2047, 10'd1023};
`endif

        iRST_n = 1'b0; iVS = 1'b1; iUpd_valid = 1'b0;
        iPos_x = 11'd0; iPos_y = 10'd0; iAction = 6'd0; iDir = 2'd0; iSpeed = 3'd0; iGrounded = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pvga", oPVGA, 128'd0);
        check("rst_commit", {127'd0, oCommit}, 128'd0);
        check("rst_frame_cnt", {112'd0, oFrame_cnt}, 128'd0);
        check("rst_drop_cnt", {120'd0, oDrop_cnt}, 128'd0);
        check("rst_ready", {127'd0, oUpd_ready}, 128'd1);
        iRST_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_commit_after_release", {127'd0, oCommit}, 128'd0);

        // Table: one accept then one frame per vector
        for (int i = 0; i < 5; i++) begin
            do_accept(vecs[i].x, vecs[i].y, vecs[i].act, vecs[i].dir, vecs[i].spd,
                      vecs[i].gnd, vecs[i].ex, vecs[i].ey);
            do_frame(1'b0);
        end

        // Three accepts between VS edges: third wins, two drops
        do_accept(11'd400, 10'd10, 6'b000001, 2'b01, 3'd1, 1'b0, 11'd400, 10'd10);
        do_accept(11'd410, 10'd20, 6'b000010, 2'b10, 3'd2, 1'b1, 11'd410, 10'd20);
        do_accept(11'd420, 10'd30, 6'b001000, 2'b00, 3'd4, 1'b1, 11'd420, 10'd30);
        check("drop_cnt_two", {120'd0, oDrop_cnt}, 128'd2);
        do_frame(1'b0);
        check("pvga_third_x", {117'd0, oPVGA[10:0]}, 128'd420);

        // Update offered during COMMIT is stalled and lands one frame later
        do_frame(1'b1);
        do_frame(1'b0);
        check("stalled_published_x", {117'd0, oPVGA[10:0]}, 128'd500);

        // Async reset between accept and VS
        do_accept(11'd600, 10'd300, 6'b100000, 2'b01, 3'd3, 1'b0, 11'd600, 10'd300);
        #2 iRST_n = 1'b0;
        #1;
        model_reset();
        check("midrst_pvga", oPVGA, 128'd0);
        check("midrst_frame_cnt", {112'd0, oFrame_cnt}, 128'd0);
        check("midrst_drop_cnt", {120'd0, oDrop_cnt}, 128'd0);
        @(negedge clk);
        iRST_n = 1'b1;
        @(negedge clk);

        // Sixteen idle frames: no commits, phase toggles at frames 8 and 16
        for (int f = 1; f <= 16; f++) begin
            do_frame(1'b0);
            if (f == 1) check("no_commit_after_rst_pvga", oPVGA, 128'd0);
            if (f == 8) check("phase_at_8", {127'd0, oPVGA[114]}, 128'd1);
        end
        check("frame_cnt_16", {112'd0, oFrame_cnt}, 128'd16);
        check("phase_at_16", {127'd0, oPVGA[114]}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
